sdram_arbiter: RTL and testbench

- Registered, parametrised successor to the combinational SDRAM mux.
- Arbitrates NUM_CH requesters (init, frame reader, fractal engine, ...) onto the single SDRAM controller command/address/write-data port.
- Holds each grant for one complete transaction: a full read burst or one write.
- Routes the controller's read-valid and write-done strobes back to the granted channel only.

---
 rtl/sdram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Registered round-robin arbiter that grants NUM_CH requesters one full SDRAM transaction at a time.
// Define SDRAM_ARB_FIXED_PRIORITY_EN to make channel 0 always win the IDLE scan (fixed priority).
module sdram_arbiter #(
    parameter int NUM_CH            = 3,
    parameter int ADDR_W            = 22,
    parameter int DATA_W            = 32,
    parameter int READ_BURST_LENGTH = 8
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_N,
    input  logic [2*NUM_CH-1:0]      i_Cmd,
    input  logic [ADDR_W*NUM_CH-1:0] i_Addr,
    input  logic [DATA_W*NUM_CH-1:0] i_Wdata,
    input  logic                     i_Data_Read_Valid,
    input  logic                     i_Data_Write_Done,
    output logic [1:0]               o_Cmd,
    output logic [ADDR_W-1:0]        o_Addr,
    output logic [DATA_W-1:0]        o_Wdata,
    output logic [NUM_CH-1:0]        o_Grant,
    output logic [NUM_CH-1:0]        o_Read_Valid,
    output logic [NUM_CH-1:0]        o_Write_Done,
    output logic                     o_Busy
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (READ_BURST_LENGTH > 1) ? $clog2(READ_BURST_LENGTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(READ_BURST_LENGTH - 1);
    localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(NUM_CH - 1);
    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_WR   = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY_RD, ST_BUSY_WR, ST_RECOVER} state_t;

    state_t              state_reg, state_next;
    logic [1:0]          cmd_reg, cmd_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [NUM_CH-1:0]   grant_reg, grant_next;
    logic [IDX_W-1:0]    owner_reg, owner_next;
    logic [IDX_W-1:0]    ptr_reg, ptr_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;

    logic [NUM_CH-1:0]   req_rd;
    logic [NUM_CH-1:0]   req_wr;
    logic [ADDR_W-1:0]   ch_addr  [NUM_CH];
    logic [DATA_W-1:0]   ch_wdata [NUM_CH];
    logic [IDX_W-1:0]    scan_base;
    logic [IDX_W-1:0]    win_idx;
    logic                win_found;

    // Unpack per-channel buses; command 11 decodes as neither read nor write.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign req_rd[gi]   = (i_Cmd[2*gi +: 2] == CMD_RD);
            assign req_wr[gi]   = (i_Cmd[2*gi +: 2] == CMD_WR);
            assign ch_addr[gi]  = i_Addr[gi*ADDR_W +: ADDR_W];
            assign ch_wdata[gi] = i_Wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
    assign scan_base = '0;
`else
    assign scan_base = ptr_reg;
`endif

    always_comb begin : p_scan
        int cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = int'(scan_base) + i;
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            if (!win_found && (req_rd[cand[IDX_W-1:0]] || req_wr[cand[IDX_W-1:0]])) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            state_reg <= ST_IDLE;
            cmd_reg   <= CMD_IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            grant_reg <= '0;
            owner_reg <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cmd_reg   <= cmd_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            grant_reg <= grant_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_next   = cmd_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        grant_next = grant_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (win_found) begin
                    grant_next = {{(NUM_CH-1){1'b0}}, 1'b1} << win_idx;
                    owner_next = win_idx;
                    addr_next  = ch_addr[win_idx];
                    wdata_next = ch_wdata[win_idx];
                    if (req_rd[win_idx]) begin
                        cmd_next   = CMD_RD;
                        state_next = ST_BUSY_RD;
                    end else begin
                        cmd_next   = CMD_WR;
                        state_next = ST_BUSY_WR;
                    end
                end
            end
            ST_BUSY_RD: begin
                if (i_Data_Read_Valid) begin
                    if (cnt_reg == LAST_BEAT) begin
                        cnt_next   = '0;
                        state_next = ST_RECOVER;
                        cmd_next   = CMD_IDLE;
                        addr_next  = '0;
                        wdata_next = '0;
                        grant_next = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            ST_BUSY_WR: begin
                if (i_Data_Write_Done) begin
                    state_next = ST_RECOVER;
                    cmd_next   = CMD_IDLE;
                    addr_next  = '0;
                    wdata_next = '0;
                    grant_next = '0;
                end
            end
            ST_RECOVER: begin
                // Next scan starts just past the channel that was served.
                ptr_next   = (owner_reg == LAST_CH) ? '0 : owner_reg + IDX_W'(1);
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign o_Cmd        = cmd_reg;
    assign o_Addr       = addr_reg;
    assign o_Wdata      = wdata_reg;
    assign o_Grant      = grant_reg;
    assign o_Busy       = (state_reg != ST_IDLE);
    assign o_Read_Valid = (state_reg == ST_BUSY_RD && i_Data_Read_Valid) ? grant_reg : '0;
    assign o_Write_Done = (state_reg == ST_BUSY_WR && i_Data_Write_Done) ? grant_reg : '0;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: stimulus queues expected grants/strobes, a negedge monitor checks them.
module tb_sdram_arbiter;

    localparam int NCH = 3;
    localparam int AW  = 22;
    localparam int DW  = 32;

    logic            clk;
    logic            rst_n;
    logic [2*NCH-1:0] cmd;
    logic [AW*NCH-1:0] addr;
    logic [DW*NCH-1:0] wdata;
    logic            rd_valid;
    logic            wr_done;
    logic [1:0]      o_cmd;
    logic [AW-1:0]   o_addr;
    logic [DW-1:0]   o_wdata;
    logic [NCH-1:0]  o_grant;
    logic [NCH-1:0]  o_rv;
    logic [NCH-1:0]  o_wd;
    logic            o_busy;

    sdram_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .READ_BURST_LENGTH(8)) dut (
        .i_Clk(clk), .i_Rst_N(rst_n), .i_Cmd(cmd), .i_Addr(addr), .i_Wdata(wdata),
        .i_Data_Read_Valid(rd_valid), .i_Data_Write_Done(wr_done),
        .o_Cmd(o_cmd), .o_Addr(o_addr), .o_Wdata(o_wdata), .o_Grant(o_grant),
        .o_Read_Valid(o_rv), .o_Write_Done(o_wd), .o_Busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] grant;
        logic [1:0]     cmd;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
    } txn_t;

    txn_t           exp_txn[$];
    logic [NCH-1:0] exp_rv[$];
    logic [NCH-1:0] exp_wd[$];
    txn_t           cur;
    bit             active;
    int             tests = 0;
    int             fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expected transaction on every rising grant, then checks the hold each cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            active = 1'b0;
        end else begin
            if (o_grant != '0) begin
                if (!active) begin
                    active = 1'b1;
                    if (exp_txn.size() == 0) begin
                        chk("unexpected_grant", 64'(o_grant), 64'h0);
                    end else begin
                        cur = exp_txn.pop_front();
                        chk("grant", 64'(o_grant), 64'(cur.grant));
                        chk("cmd",   64'(o_cmd),   64'(cur.cmd));
                        chk("addr",  64'(o_addr),  64'(cur.addr));
                        chk("wdata", 64'(o_wdata), 64'(cur.wdata));
                    end
                end else begin
                    chk("hold_cmd",  64'(o_cmd),  64'(cur.cmd));
                    chk("hold_addr", 64'(o_addr), 64'(cur.addr));
                end
            end else begin
                active = 1'b0;
            end
            if (o_rv != '0) begin
                if (exp_rv.size() == 0) chk("unexpected_read_valid", 64'(o_rv), 64'h0);
                else chk("read_valid", 64'(o_rv), 64'(exp_rv.pop_front()));
            end
            if (o_wd != '0) begin
                if (exp_wd.size() == 0) chk("unexpected_write_done", 64'(o_wd), 64'h0);
                else chk("write_done", 64'(o_wd), 64'(exp_wd.pop_front()));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd[2*ch +: 2]    = c;
        addr[AW*ch +: AW] = a;
        wdata[DW*ch +: DW] = d;
    endtask

    task automatic push_txn(input int ch, input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.grant = NCH'(1 << ch);
        t.cmd   = c;
        t.addr  = a;
        t.wdata = d;
        exp_txn.push_back(t);
    endtask

    // Drives n read beats with a one-cycle gap after the fourth; checks no early completion.
    task automatic read_beats(input int ch, input int n);
        for (int b = 0; b < n; b++) begin
            rd_valid = 1'b1;
            exp_rv.push_back(NCH'(1 << ch));
            tick;
            rd_valid = 1'b0;
            if (b == 3) tick;
            if (b == 6) chk("rd_not_early", 64'(o_cmd), 64'h1);
        end
    endtask

    task automatic drain(input string name);
        chk({name, "_txn_left"}, 64'(exp_txn.size()), 64'h0);
        chk({name, "_rv_left"},  64'(exp_rv.size()),  64'h0);
        chk({name, "_wd_left"},  64'(exp_wd.size()),  64'h0);
        exp_txn.delete();
        exp_rv.delete();
        exp_wd.delete();
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_grant"}, 64'(o_grant), 64'h0);
        chk({name, "_cmd"},   64'(o_cmd),   64'h0);
        chk({name, "_addr"},  64'(o_addr),  64'h0);
        chk({name, "_wdata"}, 64'(o_wdata), 64'h0);
        chk({name, "_busy"},  64'(o_busy),  64'h0);
    endtask

    int order[6];

    initial begin
        rst_n = 1'b0; cmd = '0; addr = '0; wdata = '0; rd_valid = 1'b0; wr_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        tick;

        // Single read on ch1 with 1-cycle grant latency.
        set_ch(1, 2'b01, 22'h000100, 32'h11111111);
        push_txn(1, 2'b01, 22'h000100, 32'h11111111);
        tick;
        chk("rd_latency_cmd", 64'(o_cmd), 64'h1);
        chk("rd_latency_grant", 64'(o_grant), 64'h2);
        read_beats(1, 8);
        set_ch(1, 2'b00, '0, '0);
        chk("rd_recover_cmd", 64'(o_cmd), 64'h0);
        chk("rd_recover_grant", 64'(o_grant), 64'h0);
        chk("rd_recover_busy", 64'(o_busy), 64'h1);
        tick;
        chk_idle_outputs("rd_idle");
        drain("read");
        $display("[TB] single read ch1 done");

        // Write on ch2, with a stray read-valid during BUSY_WR.
        set_ch(2, 2'b10, 22'h0003FF, 32'hDEADBEEF);
        push_txn(2, 2'b10, 22'h0003FF, 32'hDEADBEEF);
        tick;
        chk("wr_wdata", 64'(o_wdata), 64'hDEADBEEF);
        rd_valid = 1'b1;
        #1 chk("wr_stray_rv", 64'(o_rv), 64'h0);
        tick;
        rd_valid = 1'b0;
        wr_done = 1'b1;
        exp_wd.push_back(3'b100);
        #1 chk("wr_done_pulse", 64'(o_wd), 64'h4);
        tick;
        wr_done = 1'b0;
        set_ch(2, 2'b00, '0, '0);
        chk("wr_recover_cmd", 64'(o_cmd), 64'h0);
        chk("wr_recover_busy", 64'(o_busy), 64'h1);
        chk("wr_done_single", 64'(o_wd), 64'h0);
        tick;
        drain("write");
        $display("[TB] write ch2 done");

        // Stray strobes in IDLE, then write-done stray and address change during ch0 read.
        rd_valid = 1'b1; wr_done = 1'b1;
        #1;
        chk("idle_stray_rv", 64'(o_rv), 64'h0);
        chk("idle_stray_wd", 64'(o_wd), 64'h0);
        tick;
        rd_valid = 1'b0; wr_done = 1'b0;
        set_ch(0, 2'b01, 22'h000010, 32'h0);
        push_txn(0, 2'b01, 22'h000010, 32'h0);
        tick;
        wr_done = 1'b1;
        #1 chk("rd_stray_wd", 64'(o_wd), 64'h0);
        tick;
        wr_done = 1'b0;
        addr[0 +: AW] = 22'h000020;
        read_beats(0, 8);
        set_ch(0, 2'b00, '0, '0);
        chk("stray_recover_cmd", 64'(o_cmd), 64'h0);
        tick;
        drain("stray");
        $display("[TB] stray strobes and mid-transaction change done");

        // Reset after 3 of 8 beats, then a fresh burst needs all 8 beats.
        set_ch(1, 2'b01, 22'h000200, 32'h0);
        push_txn(1, 2'b01, 22'h000200, 32'h0);
        tick;
        for (int b = 0; b < 3; b++) begin
            rd_valid = 1'b1;
            exp_rv.push_back(3'b010);
            tick;
            rd_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("mid_reset");
        set_ch(1, 2'b00, '0, '0);
        tick;
        rst_n = 1'b1;
        drain("mid_reset");
        tick;
        set_ch(1, 2'b01, 22'h000300, 32'h0);
        push_txn(1, 2'b01, 22'h000300, 32'h0);
        tick;
        read_beats(1, 8);
        set_ch(1, 2'b00, '0, '0);
        chk("post_reset_recover_cmd", 64'(o_cmd), 64'h0);
        tick;
        drain("post_reset");
        $display("[TB] reset mid-burst done");

        // Short reset clears the round-robin pointer before the fairness test.
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
        order = '{0, 0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 0, 1, 2};
`endif
        for (int t = 0; t < 6; t++)
            push_txn(order[t], 2'b10, AW'(22'h1000 + order[t]), 32'hA0000000 + 32'(order[t]));
        for (int c = 0; c < NCH; c++)
            set_ch(c, 2'b10, AW'(22'h1000 + c), 32'hA0000000 + 32'(c));
        tick;
        for (int t = 0; t < 6; t++) begin
            wr_done = 1'b1;
            exp_wd.push_back(NCH'(1 << order[t]));
            tick;
            wr_done = 1'b0;
            if (t == 5) cmd = '0;
            else set_ch(order[t], 2'b00, '0, '0);
            chk("rr_recover_grant", 64'(o_grant), 64'h0);
            tick;
            if (t != 5) set_ch(order[t], 2'b10, AW'(22'h1000 + order[t]), 32'hA0000000 + 32'(order[t]));
            tick;
            $display("[TB] fairness txn %0d expected owner %0d", t, order[t]);
        end
        chk("rr_end_busy", 64'(o_busy), 64'h0);
        drain("fairness");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
